// File: rtl/cart_loader.sv
// cart_loader: captures an HPS ROM download into cart RAM, pads it to a power of two and publishes size/mask
module cart_loader #(
    parameter int         AW        = 15,
    parameter logic [7:0] INDEX     = 8'd0,
    parameter logic [7:0] FILL_BYTE = 8'hFF,
    parameter int         MIN_AW    = 13
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [7:0]    ram_d,
    output logic [AW:0]   cart_size,
    output logic [AW-1:0] cart_mask,
    output logic          cart_valid,
    output logic          overflow,
    output logic          busy,
    output logic          reset_req
);
    typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_t;
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL = ONE << AW;

    state_t        state_q, state_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_a_q, ram_a_d;
    logic [7:0]    ram_d_q, ram_d_d;
    logic [AW:0]   size_q, size_d;
    logic [AW-1:0] mask_q, mask_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic [AW:0]   ptr_q, ptr_d;
    logic [AW:0]   pad_q, pad_d;
    logic          start, in_range, ovf_n;
    logic [AW:0]   wr_end, size_n, pad;

    // next-state logic: size tracking includes a write coinciding with the download end
    always_comb begin
        start    = ioctl_download && ioctl_index == INDEX;
        in_range = ioctl_addr[24:AW] == '0;
        wr_end   = {1'b0, ioctl_addr[AW-1:0]} + ONE;
        size_n   = !ioctl_wr ? size_q : !in_range ? FULL : wr_end > size_q ? wr_end : size_q;
        ovf_n    = ovf_q || (ioctl_wr && !in_range);
        pad      = ONE << MIN_AW;
        for (int i = MIN_AW; i < AW; i++) pad = size_n > (ONE << i) ? ONE << (i + 1) : pad;
        state_d  = state_q;
        ram_we_d = 1'b0;
        ram_a_d  = ram_a_q;
        ram_d_d  = ram_d_q;
        size_d   = size_q;
        mask_d   = mask_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        ptr_d    = ptr_q;
        pad_d    = pad_q;
        case (state_q)
            LOAD: begin
                if (ioctl_wr && in_range) begin
                    ram_we_d = 1'b1;
                    ram_a_d  = ioctl_addr[AW-1:0];
                    ram_d_d  = ioctl_dout;
                end
                size_d = size_n;
                ovf_d  = ovf_n;
                if (!ioctl_download) begin
                    if (size_n == '0) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        mask_d  = '1;
                    end else if (size_n == pad) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        mask_d  = AW'(pad - ONE);
                    end else begin
                        state_d = FILL;
                        ptr_d   = size_n;
                        pad_d   = pad;
                    end
                end
            end
            FILL: begin
                if (start) begin
                    state_d = LOAD;
                    valid_d = 1'b0;
                    size_d  = '0;
                    ovf_d   = 1'b0;
                end else begin
                    ram_we_d = 1'b1;
                    ram_a_d  = ptr_q[AW-1:0];
                    ram_d_d  = FILL_BYTE;
                    ptr_d    = ptr_q + ONE;
                    if (ptr_q == pad_q - ONE) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        mask_d  = AW'(pad_q - ONE);
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d = LOAD;
                    valid_d = 1'b0;
                    size_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
        endcase
        busy_d = state_d == LOAD || state_d == FILL;
    end

    // register state and all outputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= IDLE;
            ram_we_q <= 1'b0;
            ram_a_q  <= '0;
            ram_d_q  <= '0;
            size_q   <= '0;
            mask_q   <= '1;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            ptr_q    <= '0;
            pad_q    <= '0;
        end else begin
            state_q  <= state_d;
            ram_we_q <= ram_we_d;
            ram_a_q  <= ram_a_d;
            ram_d_q  <= ram_d_d;
            size_q   <= size_d;
            mask_q   <= mask_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
            pad_q    <= pad_d;
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_a      = ram_a_q;
    assign ram_d      = ram_d_q;
    assign cart_size  = size_q;
    assign cart_mask  = mask_q;
    assign cart_valid = valid_q;
    assign overflow   = ovf_q;
    assign busy       = busy_q;
    assign reset_req  = busy_q;
endmodule

// File: tb/tb_cart_loader.sv
// tb_cart_loader: scoreboard bench for cart_loader; RAM writes are predicted into a queue and matched by a monitor
module tb_cart_loader;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ram_we;
    logic [14:0] ram_a;
    logic [7:0]  ram_d;
    logic [15:0] cart_size;
    logic [14:0] cart_mask;
    logic        cart_valid;
    logic        overflow;
    logic        busy;
    logic        reset_req;

    typedef struct {
        logic [14:0] a;
        logic [7:0]  d;
        int          c;
    } wr_t;

    wr_t  q[$];
    wr_t  e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n = 0;
    logic [34:0] st;

    cart_loader dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ram_we(ram_we),
        .ram_a(ram_a), .ram_d(ram_d), .cart_size(cart_size), .cart_mask(cart_mask),
        .cart_valid(cart_valid), .overflow(overflow), .busy(busy), .reset_req(reset_req)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;
    assign st = {busy, reset_req, cart_valid, overflow, cart_mask, cart_size};

    // scoreboard monitor: every RAM write must match the oldest prediction, including its cycle
    always @(negedge clk_sys) begin
        if (ram_we === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write a=%h d=%h cyc=%0d", ram_a, ram_d, cyc);
            end else begin
                e = q.pop_front();
                if (ram_a !== e.a || ram_d !== e.d || cyc != e.c) begin
                    errors++;
                    $display("FAIL ram_write got a=%h d=%h cyc=%0d want a=%h d=%h cyc=%0d", ram_a, ram_d, cyc, e.a, e.d, e.c);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic begin_dl(input logic [7:0] idx);
        ioctl_index = idx;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic end_dl;
        ioctl_download = 1'b0;
        n = cyc;
        tick();
    endtask

    task automatic wr_byte(input int a, input bit last, input bit exp);
        logic [7:0] d;
        d = 8'(a) ^ 8'(a >> 8);
        ioctl_wr = 1'b1;
        ioctl_addr = 25'(a);
        ioctl_dout = d;
        if (last) ioctl_download = 1'b0;
        if (exp && a < 32768) q.push_back('{15'(a), d, cyc + 1});
        n = cyc;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic push_fill(input int base, input int cnt);
        for (int j = 0; j < cnt; j++) q.push_back('{15'(base + j), 8'hFF, n + 2 + j});
    endtask

    task automatic test_reset;
        tick();
        tick();
        checks++; if (st !== {4'b0000, 15'h7FFF, 16'd0}) begin errors++; $display("FAIL reset_status got=%h want=%h", st, {4'b0000, 15'h7FFF, 16'd0}); end
        checks++; if ({ram_we, ram_a, ram_d} !== 24'd0) begin errors++; $display("FAIL reset_ram got=%h want=0", {ram_we, ram_a, ram_d}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_8k;
        begin_dl(8'd0);
        for (int i = 0; i < 8192; i++) begin
            wr_byte(i, 1'b0, 1'b1);
            if (i == 10) begin
                checks++; if ({busy, reset_req, cart_valid, cart_size} !== {3'b110, 16'd11}) begin errors++; $display("FAIL 8k_loading got=%h want=%h", {busy, reset_req, cart_valid, cart_size}, {3'b110, 16'd11}); end
            end
        end
        end_dl();
        checks++; if (st !== {4'b0010, 15'h1FFF, 16'd8192}) begin errors++; $display("FAIL 8k_done got=%h want=%h", st, {4'b0010, 15'h1FFF, 16'd8192}); end
        tick();
        checks++; if (q.size() != 0) begin errors++; $display("FAIL 8k_missing_writes got=%0d want=0", q.size()); end
    endtask

    task automatic test_empty;
        begin_dl(8'd0);
        tick();
        checks++; if ({busy, reset_req, cart_valid, cart_size} !== {3'b110, 16'd0}) begin errors++; $display("FAIL empty_entry got=%h want=%h", {busy, reset_req, cart_valid, cart_size}, {3'b110, 16'd0}); end
        end_dl();
        checks++; if (st !== {4'b0000, 15'h7FFF, 16'd0}) begin errors++; $display("FAIL empty_done got=%h want=%h", st, {4'b0000, 15'h7FFF, 16'd0}); end
    endtask

    task automatic test_fill_12k;
        begin_dl(8'd0);
        for (int i = 0; i < 12288; i++) begin
            wr_byte(i, i == 12287, 1'b1);
            if (i == 5000) begin
                checks++; if ({busy, reset_req} !== 2'b11) begin errors++; $display("FAIL 12k_load_busy got=%b want=11", {busy, reset_req}); end
            end
        end
        push_fill(12288, 4096);
        for (int j = 2; j <= 4096; j++) begin
            tick();
            if (j == 2000) begin
                checks++; if ({busy, reset_req, cart_valid} !== 3'b110) begin errors++; $display("FAIL 12k_fill_busy got=%b want=110", {busy, reset_req, cart_valid}); end
            end
        end
        checks++; if ({busy, reset_req} !== 2'b11) begin errors++; $display("FAIL 12k_last_fill_busy got=%b want=11", {busy, reset_req}); end
        tick();
        checks++; if (st !== {4'b0010, 15'h3FFF, 16'd12288}) begin errors++; $display("FAIL 12k_done got=%h want=%h", st, {4'b0010, 15'h3FFF, 16'd12288}); end
        tick();
        checks++; if (q.size() != 0) begin errors++; $display("FAIL 12k_missing_writes got=%0d want=0", q.size()); end
    endtask

    task automatic test_fill_100;
        begin_dl(8'd0);
        for (int i = 0; i < 100; i++) wr_byte(i, 1'b0, 1'b1);
        end_dl();
        push_fill(100, 8092);
        for (int j = 2; j <= 8092; j++) tick();
        checks++; if ({busy, cart_valid, cart_size} !== {2'b10, 16'd100}) begin errors++; $display("FAIL 100_last_fill got=%h want=%h", {busy, cart_valid, cart_size}, {2'b10, 16'd100}); end
        tick();
        checks++; if (st !== {4'b0010, 15'h1FFF, 16'd100}) begin errors++; $display("FAIL 100_done got=%h want=%h", st, {4'b0010, 15'h1FFF, 16'd100}); end
        tick();
        checks++; if (q.size() != 0) begin errors++; $display("FAIL 100_missing_writes got=%0d want=0", q.size()); end
    endtask

    task automatic test_overflow;
        begin_dl(8'd0);
        for (int i = 0; i < 16; i++) wr_byte(i, 1'b0, 1'b1);
        for (int i = 32760; i < 32776; i++) wr_byte(i, 1'b0, 1'b1);
        checks++; if ({overflow, cart_size} !== {1'b1, 16'h8000}) begin errors++; $display("FAIL ovf_load got=%h want=%h", {overflow, cart_size}, {1'b1, 16'h8000}); end
        wr_byte(39999, 1'b1, 1'b1);
        checks++; if (st !== {4'b0011, 15'h7FFF, 16'h8000}) begin errors++; $display("FAIL ovf_done got=%h want=%h", st, {4'b0011, 15'h7FFF, 16'h8000}); end
        tick();
        checks++; if (q.size() != 0) begin errors++; $display("FAIL ovf_missing_writes got=%0d want=0", q.size()); end
    endtask

    task automatic test_other_index;
        begin_dl(8'd1);
        for (int i = 0; i < 20; i++) wr_byte(i, 1'b0, 1'b0);
        checks++; if (st !== {4'b0011, 15'h7FFF, 16'h8000}) begin errors++; $display("FAIL idx1_during got=%h want=%h", st, {4'b0011, 15'h7FFF, 16'h8000}); end
        end_dl();
        tick();
        checks++; if (st !== {4'b0011, 15'h7FFF, 16'h8000}) begin errors++; $display("FAIL idx1_after got=%h want=%h", st, {4'b0011, 15'h7FFF, 16'h8000}); end
        ioctl_index = 8'd0;
    endtask

    task automatic test_reset_mid_fill;
        begin_dl(8'd0);
        for (int i = 0; i < 100; i++) wr_byte(i, i == 99, 1'b1);
        push_fill(100, 9);
        for (int j = 0; j < 9; j++) tick();
        reset = 1'b1;
        tick();
        checks++; if (st !== {4'b0000, 15'h7FFF, 16'd0}) begin errors++; $display("FAIL rst_fill_status got=%h want=%h", st, {4'b0000, 15'h7FFF, 16'd0}); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_fill_we got=%b want=0", ram_we); end
        reset = 1'b0;
        tick();
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rst_fill_missing_writes got=%0d want=0", q.size()); end
    endtask

    task automatic test_restart_mid_fill;
        begin_dl(8'd0);
        for (int i = 0; i < 100; i++) wr_byte(i, i == 99, 1'b1);
        push_fill(100, 19);
        for (int j = 0; j < 19; j++) tick();
        checks++; if ({busy, cart_valid, cart_size} !== {2'b10, 16'd100}) begin errors++; $display("FAIL restart_pre got=%h want=%h", {busy, cart_valid, cart_size}, {2'b10, 16'd100}); end
        begin_dl(8'd0);
        checks++; if ({ram_we, busy, cart_valid, cart_size} !== {3'b010, 16'd0}) begin errors++; $display("FAIL restart_entry got=%h want=%h", {ram_we, busy, cart_valid, cart_size}, {3'b010, 16'd0}); end
        for (int i = 0; i < 16; i++) wr_byte(i, 1'b0, 1'b1);
        for (int i = 8176; i < 8192; i++) wr_byte(i, i == 8191, 1'b1);
        checks++; if (st !== {4'b0010, 15'h1FFF, 16'd8192}) begin errors++; $display("FAIL restart_done got=%h want=%h", st, {4'b0010, 15'h1FFF, 16'd8192}); end
        tick();
        checks++; if (q.size() != 0) begin errors++; $display("FAIL restart_missing_writes got=%0d want=0", q.size()); end
    endtask

    initial begin
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        test_reset();
        test_8k();
        test_empty();
        test_fill_12k();
        test_fill_100();
        test_overflow();
        test_other_index();
        test_reset_mid_fill();
        test_restart_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
